// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin arbiter for the shared system bus.
// Ownership parks on the last owner, so exactly one active-low grant is
// asserted at all times. An optional hold limit forces rotation when one
// master keeps the bus while others wait. Every output comes straight from
// a flop, so no request input has a combinational path to any output.
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 0,  // contested cycles before preemption, 0 = never
    parameter int unsigned HOLD_W   = 8   // hold counter width, MAX_HOLD < 2**HOLD_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       preempt
);

    // Which of the four next-state rules applies this cycle.
    typedef enum logic [1:0] {
        DEC_KEEP    = 2'd0,  // owner still requesting, under the hold limit
        DEC_PREEMPT = 2'd1,  // owner still requesting, hold limit hit while contested
        DEC_RELEASE = 2'd2,  // owner dropped its request and someone else is waiting
        DEC_PARK    = 2'd3   // nobody is requesting
    } decision_e;

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
    localparam bit                HOLD_EN    = (MAX_HOLD != 0);

    // State flops and their next-state values.
    logic [1:0]        owner_q,    owner_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              preempt_q,  preempt_d;
    logic [3:0]        grnt_n_q,   grnt_n_d;

    // Arbitration terms.
    logic [3:0] req;          // active-high copy of the request lines
    logic [3:0] owner_mask;   // one-hot of the current owner
    logic       owner_req;
    logic       contested;
    logic       hold_limit;
    logic       next_found;
    logic [1:0] next_idx;
    decision_e  decision;

    // Scan owner+1, owner+2, owner+3 (mod 4) and return the first requester.
    // The owner itself is deliberately never a candidate here.
    function automatic logic [2:0] pick_next(input logic [3:0] r, input logic [1:0] cur);
        logic [2:0] res;
        logic [1:0] cand;
        res = {1'b0, cur};
        for (int k = 3; k >= 1; k--) begin
            // Walking from the farthest candidate to the nearest leaves the
            // lowest rotational distance as the final winner.
            cand = cur + 2'(k);
            if (r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    // Request decode and contention detection.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        req        = ~{m3_req_, m2_req_, m1_req_, m0_req_};
        owner_mask = 4'b0001 << owner_q;
        owner_req  = |(req & owner_mask);
        contested  = |(req & ~owner_mask);
        hold_limit = HOLD_EN && (hold_cnt_q >= MAX_HOLD_C);
        {next_found, next_idx} = pick_next(req, owner_q);
    end

    // Select the applicable rule in priority order.
    always_comb begin
        decision = DEC_PARK;
        if (owner_req) begin
            if (hold_limit && contested) begin
                decision = DEC_PREEMPT;
            end else begin
                decision = DEC_KEEP;
            end
        end else if (next_found) begin
            decision = DEC_RELEASE;
        end
    end

    // Next owner, hold counter and preempt pulse from the chosen rule.
    always_comb begin
        owner_d    = owner_q;
        hold_cnt_d = '0;
        preempt_d  = 1'b0;
        unique case (decision)
            DEC_KEEP: begin
                // Count only cycles where someone else is waiting; saturate.
                if (contested && (hold_cnt_q != '1)) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else if (contested) begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            DEC_PREEMPT: begin
                owner_d   = next_idx;
                preempt_d = 1'b1;
            end
            DEC_RELEASE: begin
                owner_d = next_idx;
            end
            DEC_PARK: begin
                owner_d = owner_q;
            end
            default: begin
                owner_d = owner_q;
            end
        endcase
        // Grants are registered alongside the owner so they switch on the
        // same edge and never glitch.
        grnt_n_d = ~(4'b0001 << owner_d);
    end

    // State register; reset hands the bus to master 0 immediately.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            owner_q    <= 2'd0;
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
            grnt_n_q   <= 4'b1110;
        end else begin
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
            grnt_n_q   <= grnt_n_d;
        end
    end

    // Outputs are direct flop copies.
    assign owner    = owner_q;
    assign preempt  = preempt_q;
    assign m0_grnt_ = grnt_n_q[0];
    assign m1_grnt_ = grnt_n_q[1];
    assign m2_grnt_ = grnt_n_q[2];
    assign m3_grnt_ = grnt_n_q[3];

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench for bus_arbiter with MAX_HOLD = 4.
// The driver applies one request vector per cycle and queues the hand-computed
// owner/preempt expected after the following edge; the monitor pops and compares
// just after each rising edge.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req_, m1_req_, m2_req_, m3_req_;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] owner;
    logic       preempt;

    typedef struct {
        string      name;
        logic [1:0] owner;
        logic       pre;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bus_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req_  (m0_req_),
        .m1_req_  (m1_req_),
        .m2_req_  (m2_req_),
        .m3_req_  (m3_req_),
        .m0_grnt_ (m0_grnt_),
        .m1_grnt_ (m1_grnt_),
        .m2_grnt_ (m2_grnt_),
        .m3_grnt_ (m3_grnt_),
        .owner    (owner),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Observed {owner, grants m3..m0, preempt}.
    function automatic logic [7:0] observed();
        return {1'b0, owner, m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_, preempt};
    endfunction

    // Expected {owner, grants, preempt}; grants are the one-cold decode of owner.
    function automatic logic [7:0] expected(input logic [1:0] own, input logic pre);
        logic [3:0] g;
        g = ~(4'b0001 << own);
        return {1'b0, own, g, pre};
    endfunction

    // One cycle of stimulus: req_n is {m3_req_, m2_req_, m1_req_, m0_req_}.
    task automatic step(input string name, input logic [3:0] req_n,
                        input logic [1:0] exp_owner, input logic exp_pre);
        exp_t e;
        @(negedge clk);
        {m3_req_, m2_req_, m1_req_, m0_req_} = req_n;
        e.name  = name;
        e.owner = exp_owner;
        e.pre   = exp_pre;
        exp_q.push_back(e);
    endtask

    // Monitor: compares the state presented after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.name, observed(), expected(e.owner, e.pre));
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Driver.
    initial begin
        reset = 1'b1;
        {m3_req_, m2_req_, m1_req_, m0_req_} = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", observed(), expected(2'd0, 1'b0));

        @(negedge clk);
        reset = 1'b0;

        // Park: no requests for 10 cycles, owner stays 0.
        for (int i = 0; i < 10; i++) step("park", 4'b1111, 2'd0, 1'b0);

        // Round-robin: masters 1..3 waiting, each drops one cycle after grant.
        step("rr_to1", 4'b0001, 2'd1, 1'b0);
        step("rr_to2", 4'b0011, 2'd2, 1'b0);
        step("rr_to3", 4'b0111, 2'd3, 1'b0);
        // Wrap-around: owner 3 releases with m0 and m2 waiting -> 0, not 2.
        step("wrap_to0", 4'b1010, 2'd0, 1'b0);
        step("rr_0to2", 4'b1011, 2'd2, 1'b0);

        // Hold without contention: only m2 requests for 20 cycles.
        for (int i = 0; i < 20; i++) step("hold_solo", 4'b1011, 2'd2, 1'b0);

        // Handover to m1 (scan 3, 0, 1), then m1 holds uncontested.
        step("to1", 4'b1101, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) step("m1_solo", 4'b1101, 2'd1, 1'b0);

        // Preemption: m3 requests from cycle c; rotation after edge c+4.
        for (int i = 0; i < 4; i++) step("m1_contested", 4'b0101, 2'd1, 1'b0);
        step("preempt_to3", 4'b0101, 2'd3, 1'b1);
        // Counter restarted at 0: m3 keeps for 4 more contested edges,
        // then the preempted m1 comes back round.
        for (int i = 0; i < 4; i++) step("m3_contested", 4'b0101, 2'd3, 1'b0);
        step("preempt_to1", 4'b0101, 2'd1, 1'b1);
        step("release_to3", 4'b0111, 2'd3, 1'b0);

        // Owner 2 holding, then async reset between edges.
        step("to2", 4'b1011, 2'd2, 1'b0);
        step("hold2", 4'b1011, 2'd2, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_m0_grnt", {7'd0, m0_grnt_}, 8'd0);
        check("async_reset_m2_grnt", {7'd0, m2_grnt_}, 8'd1);
        check("async_reset_owner", {6'd0, owner}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        // m2 still waiting: owner 0 is not requesting, so m2 gets it back.
        step("post_reset_to2", 4'b1011, 2'd2, 1'b0);
        step("post_reset_park", 4'b1111, 2'd2, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drain", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin bus arbiter granting the shared system bus to one of four bus masters per cycle. It sits in front of the bus master multiplexer and the slave address decoder. Its registered owner index steers the master-side mux, and the decoder then selects the slave from the winning master's address. Ownership always parks on the last owner, so exactly one grant is asserted at all times. An optional hold limit bounds how long one master can keep the bus while others wait.

## Interface

- `MAX_HOLD`, default 0: maximum consecutive contested cycles for one owner; 0 disables preemption.
- `HOLD_W`, default 8: hold counter width; `MAX_HOLD` < 2^`HOLD_W`.

Ports:

- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `m0_req_` .. `m3_req_` in 1 each: bus request, active-low.
- `m0_grnt_` .. `m3_grnt_` out 1 each: bus grant, active-low, registered.
- `owner` out 2: index of the current owner (0..3), registered, drives the bus master mux select.
- `preempt` out 1: active-high, registered; one-cycle pulse when ownership was forcibly rotated by the hold limit.

## Operation

- State:
  - `owner` (2 b).
  - `hold_cnt` (`HOLD_W` b, saturating).
  - `preempt` flag.
- Grants are a decode of `owner`: `mN_grnt_` = 0 iff `owner` == N, else 1. Exactly one grant is low at all times.
- Contested: at least one non-owner `req_` is low.
- Candidate search, each cycle: scan requesters in order owner+1, owner+2, owner+3 (mod 4). The first one with `req_` = 0 is `next`. The owner itself is not a candidate in this scan.
- Next-state rules, in priority order:
  1. **Keep.** Owner `req_` = 0 and not (`MAX_HOLD` != 0 and `hold_cnt` >= `MAX_HOLD` and contested).
     - `owner` unchanged.
     - `hold_cnt` increments (saturating at all ones) if contested, else clears to 0.
  2. **Preempt.** Owner `req_` = 0, hold limit reached, contested.
     - `owner` <= `next`, `hold_cnt` <= 0, `preempt` <= 1.
  3. **Release.** Owner `req_` = 1 and any other `req_` = 0.
     - `owner` <= `next`, `hold_cnt` <= 0.
  4. **Park.** No `req_` asserted.
     - `owner` unchanged, `hold_cnt` <= 0.
- `preempt` is 0 in every cycle not produced by rule 2.
- A preempted master that keeps `req_` low re-enters the round-robin. It is reconsidered only after the other requesters between it and itself in rotation order.
- `MAX_HOLD` = 1: a contested owner keeps the bus for exactly 1 cycle after the counter starts, i.e. rotation every 2 grant cycles.

## Timing

- Reset (async assert, sync-safe deassert is the system's responsibility):
  - `owner` = 0, `m0_grnt_` = 0, `m1_grnt_`..`m3_grnt_` = 1.
  - `hold_cnt` = 0, `preempt` = 0.
- Latency: requests sampled at rising edge t; the new grant is visible after edge t. Handover is 1 cycle after the owner deasserts `req_`, with no idle cycle.
- Reset mid-transfer: grants return to master 0 immediately (asynchronously), regardless of outstanding requests.
- A master must hold `req_` low until it sees its grant and until its transfer completes. Dropping `req_` before grant is allowed and is simply ignored.
- Simultaneous release and new requests: the release is resolved in the same edge. The lowest rotational distance from the old owner wins.
- Outputs are glitch-free: they come directly from flops or from a decode of the 2-bit `owner` flop only. There is no combinational path from any `req_` to any output.

## Test plan

- **Reset / park.** Assert `reset`, all `req_` = 1 -> `m0_grnt_` = 0, others 1, `owner` = 0. Release reset and hold for 10 cycles -> no change.
- **Round-robin.** Owner 0 with `req_` = 1; `m1_req_`, `m2_req_`, `m3_req_` = 0 held; each master drops `req_` 1 cycle after its grant -> grant sequence 1, 2, 3, one cycle each.
- **Wrap-around.** Owner = 3 releases while `m0_req_` = 0 and `m2_req_` = 0 -> `owner` = 0 next cycle (not 2).
- **Hold without contention.** `MAX_HOLD` = 4, only `m2_req_` low for 20 cycles -> `owner` stays 2 throughout, `preempt` never 1.
- **Preemption.** `MAX_HOLD` = 4, owner 1 holding, `m3_req_` goes low at cycle c -> `owner` = 3 and `preempt` = 1 for exactly one cycle after the edge at c+4. `hold_cnt` is 0 afterwards.
- **Async reset mid-ownership.** Owner 2 holding, pulse `reset` between clock edges -> `m0_grnt_` = 0 and `m2_grnt_` = 1 before the next edge.
